// File: rtl/tnoc_vc_scheduler.sv
// tnoc_vc_scheduler: per-VC FWFT flit buffers feeding one output stream, locked per packet,
// with round-robin or fixed-priority packet grants and orphan body-flit discard.
module tnoc_vc_scheduler #(
  parameter int CHANNELS       = 2,
  parameter int VC_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int FLIT_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_THRESHOLD = FIFO_DEPTH - 2,
  parameter int ARB_MODE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [VC_W-1:0]       i_vc,
  input  logic                  i_head,
  input  logic                  i_tail,
  input  logic [FLIT_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [VC_W-1:0]       o_vc,
  output logic                  o_head,
  output logic                  o_tail,
  output logic [FLIT_WIDTH-1:0] o_data,
  input  logic [CHANNELS-1:0]   i_vc_enable,
  output logic [CHANNELS-1:0]   o_almost_full,
  output logic [CHANNELS-1:0]   o_drop
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = FLIT_WIDTH + 2;

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [EW-1:0]         mem [CHANNELS][FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr [CHANNELS];
  logic [PW-1:0]         wr_ptr [CHANNELS];
  logic [CW-1:0]         count [CHANNELS];
  logic [FLIT_WIDTH-1:0] front_data [CHANNELS];
  logic [CHANNELS-1:0]   front_head, front_tail, empty, req, drop, push, pop;
  state_t                state, state_nx;
  logic [VC_W-1:0]       lock_vc, lock_vc_nx, rr_ptr, rr_ptr_nx, grant, sel;
  logic                  sel_ok, sel_head, sel_tail, ack;
  logic [FLIT_WIDTH-1:0] sel_data;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    o_ready = 1'b0;
    for (int v = 0; v < CHANNELS; v++) begin
      front_head[v]    = mem[v][rd_ptr[v]][EW-1];
      front_tail[v]    = mem[v][rd_ptr[v]][EW-2];
      front_data[v]    = mem[v][rd_ptr[v]][FLIT_WIDTH-1:0];
      empty[v]         = count[v] == '0;
      req[v]           = !empty[v] && front_head[v] && i_vc_enable[v];
      drop[v]          = !empty[v] && !front_head[v] && !(state == LOCKED && lock_vc == VC_W'(v));
      o_almost_full[v] = count[v] >= CW'(FIFO_THRESHOLD);
      if (i_vc == VC_W'(v)) o_ready = count[v] != CW'(FIFO_DEPTH);
    end
    o_drop = drop;
  end

  // Lowest requester overall, overridden in round robin by the lowest one at or above the pointer.
  always_comb begin
    grant = '0;
    for (int v = CHANNELS - 1; v >= 0; v--)
      if (req[v]) grant = VC_W'(v);
    if (ARB_MODE == 0)
      for (int v = CHANNELS - 1; v >= 0; v--)
        if (req[v] && VC_W'(v) >= rr_ptr) grant = VC_W'(v);
  end

  always_comb begin
    sel      = (state == LOCKED) ? lock_vc : grant;
    sel_ok   = 1'b0;
    sel_head = 1'b0;
    sel_tail = 1'b0;
    sel_data = '0;
    for (int v = 0; v < CHANNELS; v++)
      if (sel == VC_W'(v)) begin
        sel_ok   = !empty[v];
        sel_head = front_head[v];
        sel_tail = front_tail[v];
        sel_data = front_data[v];
      end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_vc <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nx;
      lock_vc <= lock_vc_nx;
      rr_ptr  <= rr_ptr_nx;
    end
  end

  // Any IDLE grant that does not finish its packet this cycle locks, keeping a stalled grant stable.
  always_comb begin
    state_nx   = state;
    lock_vc_nx = lock_vc;
    rr_ptr_nx  = rr_ptr;
    if (state == IDLE) begin
      if (o_valid) rr_ptr_nx = (grant == VC_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      if (o_valid && !(ack && o_tail)) begin
        state_nx   = LOCKED;
        lock_vc_nx = grant;
      end
    end else if (ack && o_tail) state_nx = IDLE;
  end

  always_comb begin
    o_valid = (state == LOCKED) ? sel_ok : |req;
    o_vc    = o_valid ? sel : '0;
    o_head  = o_valid && sel_head;
    o_tail  = o_valid && sel_tail;
    o_data  = o_valid ? sel_data : '0;
    ack     = o_valid && i_ready;
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      push[v] = i_valid && o_ready && i_vc == VC_W'(v);
      pop[v]  = (ack && sel == VC_W'(v)) || drop[v];
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < CHANNELS; v++)
      if (push[v]) mem[v][wr_ptr[v]] <= {i_head, i_tail, i_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < CHANNELS; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < CHANNELS; v++) begin
        if (push[v]) wr_ptr[v] <= inc(wr_ptr[v]);
        if (pop[v]) rd_ptr[v] <= inc(rd_ptr[v]);
        count[v] <= count[v] + CW'(push[v]) - CW'(pop[v]);
      end
    end
  end
endmodule

// File: tb/tb_tnoc_vc_scheduler.sv
// tb_tnoc_vc_scheduler: round-robin and fixed-priority schedulers on shared stimulus, checked
// against a queue-based packet model of the scheduling rules.
module tb_tnoc_vc_scheduler;
  localparam int NC = 4, FW = 16, DEPTH = 4;

  logic clk = 0, rst_n = 0, i_valid = 0, i_head = 0, i_tail = 0, i_ready = 0;
  logic [1:0] i_vc = '0;
  logic [FW-1:0] i_data = '0;
  logic [NC-1:0] i_vc_enable = '1;
  logic rr_ready, rr_valid, rr_head, rr_tail, fp_ready, fp_valid, fp_head, fp_tail;
  logic [1:0] rr_vc, fp_vc;
  logic [FW-1:0] rr_data, fp_data;
  logic [NC-1:0] rr_af, rr_drop, fp_af, fp_drop;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  tnoc_vc_scheduler #(.CHANNELS(NC), .FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH), .FIFO_THRESHOLD(2), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rr_ready), .i_vc(i_vc), .i_head(i_head),
    .i_tail(i_tail), .i_data(i_data), .o_valid(rr_valid), .i_ready(i_ready), .o_vc(rr_vc),
    .o_head(rr_head), .o_tail(rr_tail), .o_data(rr_data), .i_vc_enable(i_vc_enable),
    .o_almost_full(rr_af), .o_drop(rr_drop));

  tnoc_vc_scheduler #(.CHANNELS(NC), .FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH), .FIFO_THRESHOLD(2), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(fp_ready), .i_vc(i_vc), .i_head(i_head),
    .i_tail(i_tail), .i_data(i_data), .o_valid(fp_valid), .i_ready(i_ready), .o_vc(fp_vc),
    .o_head(fp_head), .o_tail(fp_tail), .o_data(fp_data), .i_vc_enable(i_vc_enable),
    .o_almost_full(fp_af), .o_drop(fp_drop));

  // Layout: [29] valid, [28:27] vc, [26] head, [25] tail, [24:9] data, [8:5] drop, [4] ready, [3:0] almost_full
  logic [29:0] d_out [2];
  assign d_out[0] = {rr_valid, rr_vc, rr_head, rr_tail, rr_data, rr_drop, rr_ready, rr_af};
  assign d_out[1] = {fp_valid, fp_vc, fp_head, fp_tail, fp_data, fp_drop, fp_ready, fp_af};
  localparam logic [29:0] IDLE_OUT = 30'h10;

  typedef struct packed { logic h; logic t; logic [FW-1:0] d; } flit_t;
  flit_t q [2][NC][$];
  bit lk [2], e_valid [2], e_tail [2], e_ready [2];
  int lv [2], ptr [2], e_sel [2];
  logic [NC-1:0] e_drop [2];
  logic [29:0] e_out [2];

  function automatic flit_t front(int m, int v);
    return (q[m][v].size() > 0) ? q[m][v][0] : '0;
  endfunction

  function automatic void model_eval();
    for (int m = 0; m < 2; m++) begin
      flit_t f, g;
      logic [NC-1:0] af;
      e_valid[m] = 0;
      e_sel[m] = 0;
      if (lk[m]) begin
        e_sel[m] = lv[m];
        e_valid[m] = q[m][lv[m]].size() > 0;
      end else
        for (int k = NC - 1; k >= 0; k--) begin
          int v;
          v = (m == 0) ? (ptr[m] + k) % NC : k;
          g = front(m, v);
          if (g.h && i_vc_enable[v]) begin e_sel[m] = v; e_valid[m] = 1; end
        end
      for (int v = 0; v < NC; v++) begin
        g = front(m, v);
        e_drop[m][v] = q[m][v].size() > 0 && !g.h && !(lk[m] && lv[m] == v);
        af[v] = q[m][v].size() >= 2;
      end
      f = e_valid[m] ? front(m, e_sel[m]) : '0;
      e_tail[m] = f.t;
      e_ready[m] = q[m][i_vc].size() < DEPTH;
      e_out[m] = {e_valid[m], e_valid[m] ? 2'(e_sel[m]) : 2'd0, f.h, f.t, f.d, e_drop[m], e_ready[m], af};
    end
  endfunction

  function automatic void model_clk();
    for (int m = 0; m < 2; m++) begin
      bit ack;
      ack = e_valid[m] && i_ready;
      if (!rst_n) begin
        for (int v = 0; v < NC; v++) q[m][v].delete();
        lk[m] = 0; lv[m] = 0; ptr[m] = 0;
      end else begin
        if (ack) void'(q[m][e_sel[m]].pop_front());
        for (int v = 0; v < NC; v++) if (e_drop[m][v]) void'(q[m][v].pop_front());
        if (i_valid && e_ready[m]) q[m][i_vc].push_back(flit_t'({i_head, i_tail, i_data}));
        if (!lk[m]) begin
          if (e_valid[m]) begin
            ptr[m] = (e_sel[m] + 1) % NC;
            if (!(ack && e_tail[m])) begin lk[m] = 1; lv[m] = e_sel[m]; end
          end
        end else if (ack && e_tail[m]) lk[m] = 0;
      end
    end
  endfunction

  task automatic settle(); #1; model_eval(); endtask
  task automatic step(); model_eval(); @(posedge clk); model_clk(); #1; endtask

  task automatic push(input logic [1:0] vc, input logic h, input logic t, input logic [FW-1:0] d);
    i_valid = 1; i_vc = vc; i_head = h; i_tail = t; i_data = d;
    settle(); step();
    i_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; step(); step(); rst_n = 1; settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m] !== IDLE_OUT) $display("FAIL reset m%0d: got %h want %h", m, d_out[m], IDLE_OUT);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    i_ready = 1;
    push(2'd1, 1'b1, 1'b1, 16'h00A5);
    settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][29] !== 1'b1 || d_out[m][28:27] !== 2'd1 || d_out[m][24:9] !== 16'h00A5 || d_out[m] !== e_out[m])
        $display("FAIL single m%0d: got %h want %h", m, d_out[m], e_out[m]);
      else n_pass++;
    end
    step(); settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][29] !== 1'b0) $display("FAIL single_done m%0d: valid %b want 0", m, d_out[m][29]);
      else n_pass++;
    end
  endtask

  task automatic test_lock();
    int got [2];
    bit hold [2];
    logic [29:0] held [2];
    logic [1:0] exp_vc [5];
    logic [FW-1:0] exp_d [5];
    exp_vc = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    exp_d = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0200};
    got = '{0, 0}; hold = '{0, 0};
    i_ready = 0;
    push(2'd0, 1'b1, 1'b0, 16'h0100);
    push(2'd0, 1'b0, 1'b0, 16'h0101);
    push(2'd0, 1'b0, 1'b0, 16'h0102);
    push(2'd0, 1'b0, 1'b1, 16'h0103);
    push(2'd1, 1'b1, 1'b1, 16'h0200);
    for (int c = 0; c < 30 && (got[0] < 5 || got[1] < 5); c++) begin
      i_ready = (c != 1 && c != 2);
      settle();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (d_out[m] !== e_out[m] || (hold[m] && d_out[m] !== held[m]))
          $display("FAIL lock_cycle m%0d c%0d: got %h want %h", m, c, d_out[m], hold[m] ? held[m] : e_out[m]);
        else n_pass++;
        hold[m] = d_out[m][29] && !i_ready;
        held[m] = d_out[m];
        if (d_out[m][29] && i_ready) begin
          n_chk++;
          if (got[m] >= 5 || d_out[m][28:27] !== exp_vc[got[m] % 5] || d_out[m][24:9] !== exp_d[got[m] % 5])
            $display("FAIL lock_order m%0d #%0d: got vc %0d data %h", m, got[m], d_out[m][28:27], d_out[m][24:9]);
          else n_pass++;
          got[m]++;
        end
      end
      step();
    end
    n_chk++;
    if (got[0] != 5 || got[1] != 5) $display("FAIL lock_timeout: got %0d/%0d flits want 5/5", got[0], got[1]);
    else n_pass++;
  endtask

  task automatic test_rr_fair();
    i_ready = 0;
    for (int k = 0; k < 8; k++) push(2'(k % 4), 1'b1, 1'b1, 16'(16'h0300 + k));
    settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][3:0] !== 4'hF) $display("FAIL loaded_af m%0d: got %b want 1111", m, d_out[m][3:0]);
      else n_pass++;
    end
    i_ready = 1;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_chk++;
      if (d_out[0][29] !== 1'b1 || d_out[0][28:27] !== 2'(k % 4) || d_out[0][24:9] !== 16'(16'h0300 + k))
        $display("FAIL rr_order #%0d: got vc %0d data %h want vc %0d", k, d_out[0][28:27], d_out[0][24:9], k % 4);
      else n_pass++;
      n_chk++;
      if (d_out[1][29] !== 1'b1 || d_out[1][28:27] !== 2'(k / 2) || d_out[1][24:9] !== 16'(16'h0300 + (k % 2) * 4 + k / 2))
        $display("FAIL fp_order #%0d: got vc %0d data %h want vc %0d", k, d_out[1][28:27], d_out[1][24:9], k / 2);
      else n_pass++;
      step();
    end
    i_ready = 0;
  endtask

  task automatic test_full();
    i_ready = 0;
    for (int k = 0; k < 4; k++) begin
      push(2'd0, 1'b1, 1'b1, 16'(16'h0400 + k));
      i_vc = 2'd0;
      settle();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (d_out[m][0] !== (k >= 1) || d_out[m][4] !== (k < 3))
          $display("FAIL full m%0d push%0d: af %b ready %b want %b %b", m, k + 1, d_out[m][0], d_out[m][4], k >= 1, k < 3);
        else n_pass++;
      end
    end
    i_vc = 2'd1; settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][4] !== 1'b1) $display("FAIL ready_other m%0d: got %b want 1", m, d_out[m][4]);
      else n_pass++;
    end
    i_ready = 1;
    for (int c = 0; c < 6; c++) begin
      settle();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (d_out[m] !== e_out[m]) $display("FAIL drain m%0d c%0d: got %h want %h", m, c, d_out[m], e_out[m]);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_enable();
    i_ready = 1; i_vc_enable = 4'b1101;
    push(2'd1, 1'b1, 1'b1, 16'h0055);
    for (int c = 0; c < 3; c++) begin
      settle();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (d_out[m][29] !== 1'b0 || d_out[m] !== e_out[m]) $display("FAIL masked m%0d: got %h want %h", m, d_out[m], e_out[m]);
        else n_pass++;
      end
      step();
    end
    i_vc_enable = 4'hF; settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][29] !== 1'b1 || d_out[m][28:27] !== 2'd1 || d_out[m][24:9] !== 16'h0055)
        $display("FAIL unmasked m%0d: got %h", m, d_out[m]);
      else n_pass++;
    end
    step();
    push(2'd2, 1'b0, 1'b0, 16'h0077);
    settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][8:5] !== 4'b0100 || d_out[m][29] !== 1'b0) $display("FAIL orphan_drop m%0d: drop %b want 0100", m, d_out[m][8:5]);
      else n_pass++;
    end
    step(); settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][8:5] !== 4'b0000 || d_out[m] !== e_out[m]) $display("FAIL orphan_after m%0d: got %h want %h", m, d_out[m], e_out[m]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 0;
    push(2'd2, 1'b1, 1'b0, 16'h0500);
    push(2'd2, 1'b0, 1'b0, 16'h0501);
    push(2'd2, 1'b0, 1'b0, 16'h0502);
    push(2'd2, 1'b0, 1'b1, 16'h0503);
    i_ready = 1; step(); step();
    rst_n = 0; i_ready = 0; step(); rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (d_out[m] !== IDLE_OUT || d_out[m] !== e_out[m]) $display("FAIL reset_mid m%0d c%0d: got %h want %h", m, c, d_out[m], IDLE_OUT);
        else n_pass++;
      end
      step();
    end
    i_ready = 1;
    push(2'd3, 1'b1, 1'b1, 16'hBEEF);
    settle();
    for (int m = 0; m < 2; m++) begin
      n_chk++;
      if (d_out[m][29] !== 1'b1 || d_out[m][28:27] !== 2'd3 || d_out[m][24:9] !== 16'hBEEF)
        $display("FAIL after_reset m%0d: got %h", m, d_out[m]);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_vc = 2'($urandom_range(0, 3));
      i_head = 1'($urandom_range(0, 1));
      i_tail = 1'($urandom_range(0, 1));
      i_data = 16'($urandom);
      i_ready = $urandom_range(0, 9) < 7;
      i_vc_enable = 4'($urandom) | 4'($urandom);
      rst_n = $urandom_range(0, 199) != 0;
      settle();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (d_out[m] !== e_out[m]) $display("FAIL random m%0d c%0d: got %h want %h", m, c, d_out[m], e_out[m]);
        else n_pass++;
      end
      step();
    end
    rst_n = 1; i_valid = 0; i_vc_enable = '1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_lock();
    test_rr_fair();
    test_full();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tnoc_vc_scheduler.md
# tnoc_vc_scheduler

Per-virtual-channel input buffer and packet scheduler for router input ports. It is the parametrised successor of the single-mode VC selector. Each VC gets its own FWFT FIFO. Packets are scheduled onto one output flit stream, and a channel stays locked from head flit to tail flit. Added over the previous generation: selectable round-robin or fixed-priority arbitration, a per-VC enable mask, per-VC almost-full status, and discard of orphaned non-head flits.

## Interface
- CHANNELS, 2 — number of virtual channels; ≥1.
- VC_W, $clog2(CHANNELS) or 1 if CHANNELS==1 — width of VC index.
- FLIT_WIDTH, 64 — flit payload width.
- FIFO_DEPTH, 8 — entries per VC FIFO; ≥2.
- FIFO_THRESHOLD, FIFO_DEPTH-2 — occupancy at or above which almost-full is asserted.
- ARB_MODE, 0 — 0: round robin; 1: fixed priority, lowest index wins.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  input flit valid.
- o_ready  out  1  input ready; `!full[i_vc]`; independent of i_valid.
- i_vc  in  VC_W  target VC of input flit.
- i_head  in  1  head-flit marker.
- i_tail  in  1  tail-flit marker (head+tail = single-flit packet).
- i_data  in  FLIT_WIDTH  payload.
- o_valid  out  1  output flit valid.
- i_ready  in  1  downstream ready.
- o_vc, o_head, o_tail, o_data  out  VC_W/1/1/FLIT_WIDTH  output flit fields.
- i_vc_enable  in  CHANNELS  per-VC scheduling enable; gates only new packet grants.
- o_almost_full  out  CHANNELS  count[v] ≥ FIFO_THRESHOLD.
- o_drop  out  CHANNELS  one-cycle pulse: orphan flit discarded from VC v.

## Operation
- Push: `i_valid && o_ready` writes {head, tail, data} into FIFO[i_vc].
- Pop: the FIFO pops on output ack (`o_valid && i_ready`, selected VC) or on orphan drop.
- count[v] is $clog2(FIFO_DEPTH+1) bits wide.
- Push and pop on the same VC in the same cycle leave the count unchanged.
- A full FIFO accepts no push. There is no same-cycle bypass.
- req[v] = FIFO[v] non-empty && front.head && i_vc_enable[v].
- State machine, two states: IDLE and LOCKED(lock_vc).
- IDLE:
  - Grant = arbiter(req), combinational.
  - o_valid = |req. The output fields come from the granted VC's front entry.
  - If o_valid && !(ack && front.tail): go to LOCKED, lock_vc = grant. This holds the grant stable while stalled.
  - If ack && tail: stay in IDLE.
- LOCKED:
  - o_valid = FIFO[lock_vc] non-empty. i_vc_enable is ignored.
  - On ack && tail: go to IDLE.
- Round robin: a pointer register, reset to 0.
  - Grant goes to the first req at or after the pointer, with wrap.
  - The pointer advances to grant+1 (mod CHANNELS) in each cycle IDLE issues a grant with o_valid=1, i.e. on entry to LOCKED or on a single-cycle ack of a single-flit packet.
  - The pointer is unchanged while stalled in LOCKED.
- Fixed priority: the lowest-indexed req wins. There is no pointer.
- Orphan discard: every VC whose FIFO is non-empty with front.head==0, and which is not the current locked VC, is popped that cycle with o_drop[v]=1. In IDLE no VC is locked.
- Protocol: once o_valid=1, the output fields and o_valid must stay stable until ack.

## Timing
- Reset values (rst_n sampled low at clk edge):
  - All counts 0, state IDLE, RR pointer 0.
  - o_valid=0, o_ready=1, o_almost_full=0, o_drop=0.
  - o_vc, o_head, o_tail, o_data = 0 when o_valid=0.
- Reset mid-packet flushes all FIFOs and the lock immediately. There is no partial-packet recovery.
- Latency: a flit pushed in cycle N is visible at the output in cycle N+1 at the earliest, if its VC is granted or locked.
- Throughput: 1 flit/cycle within a packet.
- Back-to-back packets: same or different VC, with no idle cycle when the next head is already buffered.
- o_almost_full and o_ready reflect the registered counts, valid from cycle N+1 after the push or pop.
- A simultaneous tail ack and a new head in another VC: the new head is granted in the next cycle (IDLE then).

## Test plan
- Reset then single flits:
  - Drive reset; expect o_ready=1, o_valid=0, o_almost_full=0.
  - Push a single-flit packet, VC1, data 0xA5 at cycle N; expect o_valid at N+1 with o_vc=1, o_data=0xA5.
- Lock across VCs:
  - CHANNELS=2, DEPTH=8, round robin.
  - 4-flit packet on VC0, then head on VC1 with i_ready=1.
  - Expect all 4 VC0 flits contiguous, then VC1. Insert i_ready=0 mid-packet and expect fields held stable.
- Round-robin fairness:
  - CHANNELS=4, all VCs continuously loaded with single-flit packets.
  - Expect o_vc sequence 0,1,2,3,0,…
  - Same stimulus with ARB_MODE=1: expect o_vc=0 until VC0 is empty.
- Full/threshold:
  - DEPTH=4, THRESHOLD=2, i_ready=0, push to VC0.
  - Expect almost-full after the 2nd push. With i_vc=0, expect o_ready=0 after the 4th push.
  - Expect o_ready=1 for i_vc=1.
- Enable mask and orphan drop:
  - i_vc_enable=0 on VC1 holding a head: expect no grant. Enable it: grant next cycle.
  - Push a body flit (head=0) to idle VC2: expect o_drop[2] pulse one cycle later and count[2] back to 0.
- Reset mid-packet:
  - Assert rst_n=0 after 2 of 4 flits; release.
  - Expect IDLE, empty FIFOs, o_valid=0, and a new packet served normally.
